// File: rtl/nrisc_defs_pkg.sv
// Shared definitions for the nRisc data-memory arbiter: FSM encodings,
// port indices, default widths and a saturating counter helper.
package nrisc_defs;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    ESPERA   = 2'd2,
    RESPOSTA = 2'd3
  } estado_e;

  localparam logic PORTA_CORE  = 1'b0;
  localparam logic PORTA_CARGA = 1'b1;

  localparam int LARGURA_DADOS_PADRAO    = 8;
  localparam int LARGURA_END_PADRAO      = 8;
  localparam int LATENCIA_LEITURA_PADRAO = 1;
  localparam int LARGURA_CONFLITOS       = 8;

  function automatic logic [LARGURA_CONFLITOS-1:0] incr_saturado(
    input logic [LARGURA_CONFLITOS-1:0] valor
  );
    return (&valor) ? valor : valor + LARGURA_CONFLITOS'(1);
  endfunction

endpackage

// File: rtl/arbitro_memoria_dados_seletor_round_robin.sv
// Combinational two-way round-robin selector: a lone request wins outright,
// a contested one goes to the port that did not win the previous contest.
module seletor_round_robin
  import nrisc_defs::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic ultimo,
  output logic grant_valido,
  output logic grant_indice
);

  assign grant_valido = Req0 | Req1;
  assign grant_indice = (Req0 && Req1) ? ~ultimo
                                       : (Req1 ? PORTA_CARGA : PORTA_CORE);

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter/sequencer in front of the single-port nRisc data memory.
// Serialises core and loader accesses, issues strobes and per-port acks.
module arbitro_memoria_dados
  import nrisc_defs::*;
#(
  parameter int LARGURA_DADOS    = LARGURA_DADOS_PADRAO,
  parameter int LARGURA_END      = LARGURA_END_PADRAO,
  parameter int LATENCIA_LEITURA = LATENCIA_LEITURA_PADRAO
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Req0,
  input  logic                         Req1,
  input  logic                         Write0,
  input  logic                         Write1,
  input  logic [LARGURA_END-1:0]       Endereco0,
  input  logic [LARGURA_END-1:0]       Endereco1,
  input  logic [LARGURA_DADOS-1:0]     DadoEscr0,
  input  logic [LARGURA_DADOS-1:0]     DadoEscr1,
  output logic                         Ack0,
  output logic                         Ack1,
  output logic [LARGURA_DADOS-1:0]     DadoLido0,
  output logic [LARGURA_DADOS-1:0]     DadoLido1,
  output logic [LARGURA_END-1:0]       MemEndereco,
  output logic [LARGURA_DADOS-1:0]     MemDadoEscr,
  output logic                         MemWrite,
  output logic                         MemRead,
  input  logic [LARGURA_DADOS-1:0]     MemDadoLido,
  output logic [LARGURA_CONFLITOS-1:0] ContadorConflitos
);

  localparam int LARGURA_ESPERA =
    (LATENCIA_LEITURA > 1) ? $clog2(LATENCIA_LEITURA) : 1;

  estado_e                      state_q, state_d;
  logic                         ultimo_q, ultimo_d;
  logic                         porta_q, porta_d;
  logic                         escrita_q, escrita_d;
  logic [LARGURA_ESPERA-1:0]    espera_q, espera_d;
  logic [LARGURA_CONFLITOS-1:0] conflitos_q, conflitos_d;
  logic                         ack0_q, ack0_d, ack1_q, ack1_d;
  logic [LARGURA_DADOS-1:0]     dado_lido0_q, dado_lido0_d;
  logic [LARGURA_DADOS-1:0]     dado_lido1_q, dado_lido1_d;
  logic [LARGURA_END-1:0]       mem_end_q, mem_end_d;
  logic [LARGURA_DADOS-1:0]     mem_dado_q, mem_dado_d;
  logic                         mem_write_q, mem_write_d;
  logic                         mem_read_q, mem_read_d;

  logic grant_valido, grant_indice, escrita_sel;

  seletor_round_robin u_seletor (
    .Req0         (Req0),
    .Req1         (Req1),
    .ultimo       (ultimo_q),
    .grant_valido (grant_valido),
    .grant_indice (grant_indice)
  );

  assign escrita_sel = (grant_indice == PORTA_CARGA) ? Write1 : Write0;

  always_comb begin
    // NOTE: every _d gets a default first so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    ultimo_d     = ultimo_q;
    porta_d      = porta_q;
    escrita_d    = escrita_q;
    espera_d     = espera_q;
    conflitos_d  = conflitos_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    dado_lido0_d = dado_lido0_q;
    dado_lido1_d = dado_lido1_q;
    mem_end_d    = mem_end_q;
    mem_dado_d   = mem_dado_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (Req0 && Req1) begin
          conflitos_d = incr_saturado(conflitos_q);
          ultimo_d    = grant_indice;
        end
        if (grant_valido) begin
          // Strobes and write acks are registered here so they appear in ACESSO.
          porta_d     = grant_indice;
          escrita_d   = escrita_sel;
          mem_end_d   = (grant_indice == PORTA_CARGA) ? Endereco1 : Endereco0;
          mem_dado_d  = (grant_indice == PORTA_CARGA) ? DadoEscr1 : DadoEscr0;
          mem_write_d = escrita_sel;
          mem_read_d  = ~escrita_sel;
          ack0_d      = escrita_sel && (grant_indice == PORTA_CORE);
          ack1_d      = escrita_sel && (grant_indice == PORTA_CARGA);
          state_d     = ACESSO;
        end
      end
      ACESSO: begin
        if (escrita_q) begin
          state_d = OCIOSO;
        end else begin
          espera_d = LARGURA_ESPERA'(LATENCIA_LEITURA - 1);
          state_d  = ESPERA;
        end
      end
      ESPERA: begin
        if (espera_q == '0) begin
          if (porta_q == PORTA_CORE) begin
            dado_lido0_d = MemDadoLido;
            ack0_d       = 1'b1;
          end else begin
            dado_lido1_d = MemDadoLido;
            ack1_d       = 1'b1;
          end
          state_d = RESPOSTA;
        end else begin
          espera_d = espera_q - LARGURA_ESPERA'(1);
        end
      end
      RESPOSTA: state_d = OCIOSO;
      default:  state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= OCIOSO;
      ultimo_q     <= PORTA_CARGA;
      porta_q      <= PORTA_CORE;
      escrita_q    <= 1'b0;
      espera_q     <= '0;
      conflitos_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      dado_lido0_q <= '0;
      dado_lido1_q <= '0;
      mem_end_q    <= '0;
      mem_dado_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ultimo_q     <= ultimo_d;
      porta_q      <= porta_d;
      escrita_q    <= escrita_d;
      espera_q     <= espera_d;
      conflitos_q  <= conflitos_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      dado_lido0_q <= dado_lido0_d;
      dado_lido1_q <= dado_lido1_d;
      mem_end_q    <= mem_end_d;
      mem_dado_q   <= mem_dado_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign Ack0              = ack0_q;
  assign Ack1              = ack1_q;
  assign DadoLido0         = dado_lido0_q;
  assign DadoLido1         = dado_lido1_q;
  assign MemEndereco       = mem_end_q;
  assign MemDadoEscr       = mem_dado_q;
  assign MemWrite          = mem_write_q;
  assign MemRead           = mem_read_q;
  assign ContadorConflitos = conflitos_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: two instances (read latency 1 and 3),
// each with a behavioural memory, checked against a transaction-level model.
module tb_arbitro_memoria_dados;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       req [2][2];
  logic       wr  [2][2];
  logic [7:0] adr [2][2];
  logic [7:0] dat [2][2];
  logic       ack [2][2];
  logic [7:0] dl  [2][2];
  logic [7:0] mend [2];
  logic [7:0] mdat [2];
  logic [7:0] mdl  [2];
  logic [7:0] cnt  [2];
  logic       mw   [2];
  logic       mr   [2];

  // Memory attached to each instance: writes commit on the edge where MemWrite
  // is seen; read data emerges LATENCIA_LEITURA cycles after MemRead.
  logic [7:0] mem_sim [2][256];
  logic [7:0] pipe    [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mw[i]) mem_sim[i][mend[i]] <= mdat[i];
      pipe[i][0] <= mr[i] ? mem_sim[i][mend[i]] : 8'h00;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign mdl[0] = pipe[0][0];
  assign mdl[1] = pipe[1][2];

  arbitro_memoria_dados #(.LATENCIA_LEITURA(1)) u_dut (
    .Clock(clk), .Reset(rst[0]),
    .Req0(req[0][0]), .Req1(req[0][1]), .Write0(wr[0][0]), .Write1(wr[0][1]),
    .Endereco0(adr[0][0]), .Endereco1(adr[0][1]),
    .DadoEscr0(dat[0][0]), .DadoEscr1(dat[0][1]),
    .Ack0(ack[0][0]), .Ack1(ack[0][1]), .DadoLido0(dl[0][0]), .DadoLido1(dl[0][1]),
    .MemEndereco(mend[0]), .MemDadoEscr(mdat[0]), .MemWrite(mw[0]), .MemRead(mr[0]),
    .MemDadoLido(mdl[0]), .ContadorConflitos(cnt[0])
  );

  arbitro_memoria_dados #(.LATENCIA_LEITURA(3)) u_dut_lat3 (
    .Clock(clk), .Reset(rst[1]),
    .Req0(req[1][0]), .Req1(req[1][1]), .Write0(wr[1][0]), .Write1(wr[1][1]),
    .Endereco0(adr[1][0]), .Endereco1(adr[1][1]),
    .DadoEscr0(dat[1][0]), .DadoEscr1(dat[1][1]),
    .Ack0(ack[1][0]), .Ack1(ack[1][1]), .DadoLido0(dl[1][0]), .DadoLido1(dl[1][1]),
    .MemEndereco(mend[1]), .MemDadoEscr(mdat[1]), .MemWrite(mw[1]), .MemRead(mr[1]),
    .MemDadoLido(mdl[1]), .ContadorConflitos(cnt[1])
  );

  // Reference model: memory contents, last read value per port, conflict count.
  logic [7:0] model_mem [2][256];
  bit         wrote     [2][256];
  logic [7:0] last_rd   [2][2];
  int         cnt_exp   [2];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int i);
    cnt_exp[i]    = 0;
    last_rd[i][0] = 8'h00;
    last_rd[i][1] = 8'h00;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    step();
    rst[i] = 1'b0;
    model_reset(i);
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One uncontested transaction; called in an idle cycle, returns in an idle cycle.
  task automatic run_txn(input int i, input int p, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    int lat = (i == 0) ? 1 : 3;
    int o   = 1 - p;
    req[i][p] = 1'b1; wr[i][p] = w; adr[i][p] = a; dat[i][p] = d;
    step();
    req[i][p] = 1'b0;
    if (w) begin
      check("ack_escrita", ack[i][p], 1);
      check("ack_outra", ack[i][o], 0);
      check("memwrite", mw[i], 1);
      check("memread_em_escrita", mr[i], 0);
      check("mem_endereco", mend[i], a);
      check("mem_dado_escr", mdat[i], d);
      model_mem[i][a] = d;
      wrote[i][a]     = 1'b1;
    end else begin
      check("memread", mr[i], 1);
      check("memwrite_em_leitura", mw[i], 0);
      check("mem_endereco_rd", mend[i], a);
      check("ack_cedo_acesso", ack[i][p], 0);
      for (int k = 0; k < lat; k++) begin
        step();
        check("memread_pulso_unico", mr[i], 0);
        check("ack_cedo_espera", ack[i][p], 0);
      end
      step();
      check("ack_leitura", ack[i][p], 1);
      check("ack_outra_rd", ack[i][o], 0);
      check("dado_lido", dl[i][p], model_mem[i][a]);
      check("dado_lido_outra", dl[i][o], last_rd[i][o]);
      last_rd[i][p] = model_mem[i][a];
    end
    step();
    check("ack_apos", ack[i][p], 0);
    check("conflitos_sem_disputa", cnt[i], cnt_exp[i]);
  endtask

  initial begin
    logic [7:0] a, d, d2, da, db;
    int         e;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; wr[i][p] = 1'b0; adr[i][p] = 8'h00; dat[i][p] = 8'h00;
      end
      model_reset(i);
    end

    // Reset values.
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      check("rst_ack0", ack[i][0], 0);
      check("rst_ack1", ack[i][1], 0);
      check("rst_dl0", dl[i][0], 0);
      check("rst_dl1", dl[i][1], 0);
      check("rst_memwrite", mw[i], 0);
      check("rst_memread", mr[i], 0);
      check("rst_mem_end", mend[i], 0);
      check("rst_conflitos", cnt[i], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Directed write then read-back across ports.
    run_txn(0, 0, 1'b1, 8'h10, 8'hA5);
    run_txn(0, 1, 1'b0, 8'h10, 8'h00);

    // Randomized uncontested traffic on a small address window.
    for (int n = 0; n < 40; n++) begin
      int   p = int'($urandom_range(0, 1));
      logic w;
      a = 8'(8'h10 + $urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) || !wrote[0][a];
      d = 8'($urandom);
      run_txn(0, p, w, a, d);
    end

    // Both ports writing continuously: grants alternate starting with port 0.
    da = 8'($urandom); db = 8'($urandom);
    req[0][0] = 1'b1; wr[0][0] = 1'b1; adr[0][0] = 8'h20; dat[0][0] = da;
    req[0][1] = 1'b1; wr[0][1] = 1'b1; adr[0][1] = 8'h21; dat[0][1] = db;
    do_reset(0);
    e = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      cnt_exp[0] = sat_inc(cnt_exp[0]);
      check("disputa_ack_vencedor", ack[0][e], 1);
      check("disputa_ack_perdedor", ack[0][1-e], 0);
      check("disputa_conflitos", cnt[0], cnt_exp[0]);
      check("disputa_mem_end", mend[0], (e == 0) ? 8'h20 : 8'h21);
      step();
      check("disputa_ack_duplo", ack[0][0] & ack[0][1], 0);
      e = 1 - e;
    end
    model_mem[0][8'h20] = da; wrote[0][8'h20] = 1'b1;
    model_mem[0][8'h21] = db; wrote[0][8'h21] = 1'b1;

    // Keep contending long enough to saturate the conflict counter.
    for (int n = 0; n < 600; n++) begin
      step();
      if (n % 2 == 0) cnt_exp[0] = sat_inc(cnt_exp[0]);
      check("saturacao_ack_duplo", ack[0][0] & ack[0][1], 0);
    end
    check("conflitos_saturado", cnt[0], cnt_exp[0]);
    check("conflitos_ff", cnt[0], 8'hFF);
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    step();
    check("conflitos_mantem_ff", cnt[0], 8'hFF);
    run_txn(0, 1, 1'b0, 8'h21, 8'h00);

    // Reset during ESPERA of a port-1 read abandons it.
    do_reset(0);
    d  = 8'($urandom) | 8'h01;
    d2 = 8'($urandom);
    run_txn(0, 1, 1'b1, 8'h40, d);
    run_txn(0, 1, 1'b0, 8'h40, 8'h00);
    req[0][1] = 1'b1; wr[0][1] = 1'b0; adr[0][1] = 8'h40;
    step();
    req[0][1] = 1'b0;
    check("aborto_memread", mr[0], 1);
    step();
    check("aborto_sem_ack_espera", ack[0][1], 0);
    rst[0] = 1'b1;
    req[0][0] = 1'b1; wr[0][0] = 1'b1; adr[0][0] = 8'h41; dat[0][0] = d2;
    req[0][1] = 1'b1; wr[0][1] = 1'b1; adr[0][1] = 8'h42; dat[0][1] = 8'h00;
    step();
    model_reset(0);
    check("aborto_ack0", ack[0][0], 0);
    check("aborto_ack1", ack[0][1], 0);
    check("aborto_dl0", dl[0][0], 0);
    check("aborto_dl1", dl[0][1], 0);
    check("aborto_memwrite", mw[0], 0);
    check("aborto_memread_zero", mr[0], 0);
    check("aborto_mem_end", mend[0], 0);
    check("aborto_mem_dado", mdat[0], 0);
    check("aborto_conflitos", cnt[0], 0);
    rst[0] = 1'b0;
    step();
    cnt_exp[0] = sat_inc(cnt_exp[0]);
    check("pos_reset_ack0_primeiro", ack[0][0], 1);
    check("pos_reset_ack1", ack[0][1], 0);
    check("pos_reset_dado", mdat[0], d2);
    check("pos_reset_conflitos", cnt[0], cnt_exp[0]);
    model_mem[0][8'h41] = d2; wrote[0][8'h41] = 1'b1;
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    step();
    run_txn(0, 0, 1'b0, 8'h41, 8'h00);

    // Read latency 3 instance.
    a = 8'h77;
    d = 8'($urandom);
    run_txn(1, 0, 1'b1, a, d);
    run_txn(1, 1, 1'b0, a, 8'h00);
    run_txn(1, 0, 1'b0, a, 8'h00);
    for (int n = 0; n < 8; n++) begin
      int   p = int'($urandom_range(0, 1));
      logic w;
      a = 8'(8'h70 + $urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) || !wrote[1][a];
      run_txn(1, p, w, a, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
